// File: rtl/naozhong_buzzer_pkg.sv
// Shared types and helpers for the alarm buzzer stage.
package naozhong_buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } nz_state_e;

  // Width that holds 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/naozhong_buzzer_tick_gen.sv
// Free-running strobe: one-clock pulse every DIV clocks, phase set by reset.
module tick_gen
  import naozhong_buzzer_pkg::*;
#(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = cw(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  // Divider counter, wraps on the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/naozhong_buzzer.sv
// Alarm buzzer: turns the comparator match level into a gated beep cadence
// with stop, snooze and auto-timeout; DONE holds off retrigger for the minute.
module naozhong_buzzer
  import naozhong_buzzer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TONE_HZ     = 2_000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 200,
  parameter int TIMEOUT_MS  = 60_000,
  parameter int SNOOZE_MS   = 300_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic audio,
  input  logic stop_key,
  input  logic snooze_key,
  output logic buzzer,
  output logic ringing,
  output logic snoozing
);

  localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int BEEP_P = BEEP_ON_MS + BEEP_OFF_MS;
  localparam int RW     = cw(TIMEOUT_MS);
  localparam int SW     = cw(SNOOZE_MS);
  localparam int BW     = cw(BEEP_P);
  localparam int TW     = cw(HALF);

  logic          ms_tick;
  logic [2:0]    stp_sr, snz_sr;
  logic          audio_d;
  logic          stp_rise, snz_rise, a_rise;

  nz_state_e     state, nxt;
  logic [RW-1:0] ring_ms, ring_n;
  logic [SW-1:0] snz_ms, snz_n;
  logic [BW-1:0] beep_ms, beep_n;
  logic [TW-1:0] tone_cnt, tone_cnt_n;
  logic          tone_q, tone_q_n;
  logic          enter_ring;
  logic          beep_on_n;

  tick_gen #(.DIV(CLK_HZ / 1000)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (ms_tick)
  );

  // Two-stage synchronizers plus one edge-history stage for each key;
  // audio_d resets high so a level already present at release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stp_sr  <= '0;
      snz_sr  <= '0;
      audio_d <= 1'b1;
    end else begin
      stp_sr  <= {stp_sr[1:0], stop_key};
      snz_sr  <= {snz_sr[1:0], snooze_key};
      audio_d <= audio;
    end
  end

  assign stp_rise = stp_sr[1] & ~stp_sr[2];
  assign snz_rise = snz_sr[1] & ~snz_sr[2];
  assign a_rise   = audio & ~audio_d;

  // Next state and counter updates; stop outranks snooze and timeout.
  always_comb begin
    nxt        = state;
    ring_n     = ring_ms;
    snz_n      = snz_ms;
    beep_n     = beep_ms;
    tone_cnt_n = tone_cnt;
    tone_q_n   = tone_q;
    enter_ring = 1'b0;
    case (state)
      IDLE: begin
        if (a_rise) begin
          nxt        = RING;
          enter_ring = 1'b1;
        end
      end
      RING: begin
        if (stp_rise) nxt = DONE;
        else if (snz_rise) begin
          nxt   = SNOOZE;
          snz_n = '0;
        end else if (ms_tick && ring_ms == RW'(TIMEOUT_MS - 1)) nxt = DONE;
        else begin
          if (tone_cnt == TW'(HALF - 1)) begin
            tone_cnt_n = '0;
            tone_q_n   = ~tone_q;
          end else tone_cnt_n = tone_cnt + 1'b1;
          if (ms_tick) begin
            ring_n = ring_ms + 1'b1;
            beep_n = (beep_ms == BW'(BEEP_P - 1)) ? '0 : beep_ms + 1'b1;
          end
        end
      end
      SNOOZE: begin
        if (stp_rise) nxt = DONE;
        else if (ms_tick && snz_ms == SW'(SNOOZE_MS - 1)) begin
          nxt        = RING;
          enter_ring = 1'b1;
        end else if (ms_tick) snz_n = snz_ms + 1'b1;
      end
      default: begin
        if (!audio) nxt = IDLE;
      end
    endcase
    if (enter_ring) begin
      ring_n     = '0;
      beep_n     = '0;
      tone_cnt_n = '0;
      tone_q_n   = 1'b0;
    end
    beep_on_n = (int'(beep_n) < BEEP_ON_MS);
  end

  // State, counters and outputs; outputs follow the next state so they
  // drop on the same edge the state leaves RING/SNOOZE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ring_ms  <= '0;
      snz_ms   <= '0;
      beep_ms  <= '0;
      tone_cnt <= '0;
      tone_q   <= 1'b0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      state    <= nxt;
      ring_ms  <= ring_n;
      snz_ms   <= snz_n;
      beep_ms  <= beep_n;
      tone_cnt <= tone_cnt_n;
      tone_q   <= tone_q_n;
      ringing  <= (nxt == RING);
      snoozing <= (nxt == SNOOZE);
      buzzer   <= (nxt == RING) & tone_q_n & beep_on_n;
    end
  end

endmodule
